// File: rtl/wb_regfile.sv
// wb_regfile: W-stage write-back data select feeding a 32x32 GPR file with same-cycle read bypass.
// Optional build macro WB_DISPLAY_EN prints one trace line per committed register write.
module wb_regfile (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR_W,
  input  logic [4:0]  A3_W,
  input  logic [31:0] PC4_W,
  input  logic [31:0] AMO_W,
  input  logic [31:0] DR_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_W,
  output logic        WE_W
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] FN_JALR  = 6'h09;

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic        unused_ir_s;

  assign unused_ir_s = ^IR_W[25:6];

  // Write-back data select and write enable
  always_comb begin
    opcode_s = IR_W[31:26];
    funct_s  = IR_W[5:0];
    case (AMO_W[1:0])
      2'd0:    byte_s = DR_W[7:0];
      2'd1:    byte_s = DR_W[15:8];
      2'd2:    byte_s = DR_W[23:16];
      2'd3:    byte_s = DR_W[31:24];
      default: byte_s = DR_W[7:0];
    endcase
    // Halfword loads never trap on misalignment; only AMO_W[1] picks the half.
    if (AMO_W[1]) begin
      half_s = DR_W[31:16];
    end else begin
      half_s = DR_W[15:0];
    end
    case (opcode_s)
      OP_LW:   WD_W = DR_W;
      OP_LB:   WD_W = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  WD_W = {24'd0, byte_s};
      OP_LH:   WD_W = {{16{half_s[15]}}, half_s};
      OP_LHU:  WD_W = {16'd0, half_s};
      OP_JAL:  WD_W = PC4_W + 32'd4;
      OP_RTYPE: begin
        if (funct_s == FN_JALR) begin
          WD_W = PC4_W + 32'd4;
        end else begin
          WD_W = AMO_W;
        end
      end
      default: WD_W = AMO_W;
    endcase
    WE_W = (A3_W != 5'd0);
  end

  // Next-state of the register file; $0 is pinned to zero
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      if (WE_W && (A3_W == 5'(i))) begin
        gpr_d[i] = WD_W;
      end else begin
        gpr_d[i] = gpr_q[i];
      end
    end
    gpr_d[0] = 32'd0;
  end

  // Register storage with asynchronous clear
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
`ifdef WB_DISPLAY_EN
      if (WE_W) begin
        $display("@%08h: $%02d <= %08h", PC4_W - 32'd4, A3_W, WD_W);
      end
`else
`endif
    end
  end

  // Read port 1 with same-cycle bypass from the write-back stage
  always_comb begin
    if (A1 == 5'd0) begin
      RD1 = 32'd0;
    end else if (WE_W && (A1 == A3_W)) begin
      RD1 = WD_W;
    end else begin
      RD1 = gpr_q[A1];
    end
  end

  // Read port 2 with same-cycle bypass from the write-back stage
  always_comb begin
    if (A2 == 5'd0) begin
      RD2 = 32'd0;
    end else if (WE_W && (A2 == A3_W)) begin
      RD2 = WD_W;
    end else begin
      RD2 = gpr_q[A2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a behavioural model.
`timescale 1ns/1ps
module tb_wb_regfile;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] IR_W = 32'd0, PC4_W = 32'd0, AMO_W = 32'd0, DR_W = 32'd0;
  logic [4:0]  A3_W = 5'd0, A1 = 5'd0, A2 = 5'd0;
  logic [31:0] RD1, RD2, WD_W;
  logic        WE_W;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_regs [32];

  wb_regfile dut (
    .Clock(Clock), .Reset(Reset), .IR_W(IR_W), .A3_W(A3_W), .PC4_W(PC4_W),
    .AMO_W(AMO_W), .DR_W(DR_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .WD_W(WD_W), .WE_W(WE_W)
  );

  always #5 Clock = ~Clock;

  // Write-back value from the architectural rules, using plain arithmetic
  function automatic logic [31:0] f_wd(input logic [31:0] ir, input logic [31:0] pc4,
                                       input logic [31:0] amo, input logic [31:0] dr);
    int unsigned op, fn, bv, hv;
    op = ir >> 26;
    fn = ir % 64;
    bv = (dr >> (8 * (amo % 4))) % 256;
    hv = (dr >> (16 * ((amo / 2) % 2))) % 65536;
    if (op == 'h23) return dr;
    if (op == 'h24) return 32'(bv);
    if (op == 'h20) return (bv >= 128) ? 32'(bv) - 32'd256 : 32'(bv);
    if (op == 'h25) return 32'(hv);
    if (op == 'h21) return (hv >= 32768) ? 32'(hv) - 32'd65536 : 32'(hv);
    if (op == 'h03 || (op == 0 && fn == 'h09)) return pc4 + 32'd4;
    return amo;
  endfunction

  function automatic logic [31:0] f_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (A3_W != 5'd0 && a == A3_W) return f_wd(IR_W, PC4_W, AMO_W, DR_W);
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference storage: async clear, commit on edge when a destination is given
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (A3_W != 5'd0) begin
      m_regs[A3_W] = f_wd(IR_W, PC4_W, AMO_W, DR_W);
    end
  end

  // Per-cycle compare against the model, mid-cycle
  always @(negedge Clock) begin
    check("we", {31'd0, WE_W}, {31'd0, (A3_W != 5'd0)});
    check("wd", WD_W, f_wd(IR_W, PC4_W, AMO_W, DR_W));
    check("rd1", RD1, f_rd(A1));
    check("rd2", RD2, f_rd(A2));
  end

  task automatic drive(input logic [31:0] ir, input logic [4:0] a3, input logic [31:0] pc4,
                       input logic [31:0] amo, input logic [31:0] dr,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(posedge Clock);
    #1;
    IR_W = ir; A3_W = a3; PC4_W = pc4; AMO_W = amo; DR_W = dr; A1 = a1; A2 = a2;
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input int unsigned op, input int unsigned fn);
    return (32'(op) << 26) | 32'(fn);
  endfunction

  initial begin
    logic [31:0] ops [8];
    ops[0] = mk_ir(6'h00, 6'h21); ops[1] = mk_ir(6'h00, 6'h09);
    ops[2] = mk_ir(6'h03, 6'h00); ops[3] = mk_ir(6'h20, 6'h00);
    ops[4] = mk_ir(6'h21, 6'h00); ops[5] = mk_ir(6'h23, 6'h00);
    ops[6] = mk_ir(6'h24, 6'h00); ops[7] = mk_ir(6'h25, 6'h00);

    #1 Reset = 1'b1;
    #1;
    A1 = 5'd3; A2 = 5'd31;
    #1;
    check("reset_rd1", RD1, 32'd0);
    check("reset_rd2", RD2, 32'd0);
    check("reset_we", {31'd0, WE_W}, 32'd0);
    @(posedge Clock);
    #1 Reset = 1'b0;

    // lb / lbu byte 2 of 0x11802233
    drive(mk_ir(6'h20, 6'h00), 5'd8, 32'd0, 32'h3002, 32'h11802233, 5'd8, 5'd0);
    check("lb_wd", WD_W, 32'hFFFFFF80);
    drive(mk_ir(6'h24, 6'h00), 5'd0, 32'd0, 32'h3002, 32'h11802233, 5'd8, 5'd0);
    check("lb_stored", RD1, 32'hFFFFFF80);
    check("lbu_wd", WD_W, 32'h00000080);
    // jal link
    drive(mk_ir(6'h03, 6'h00), 5'd31, 32'h3004, 32'd0, 32'd0, 5'd0, 5'd0);
    check("jal_wd", WD_W, 32'h00003008);
    drive(32'd0, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0, 5'd31, 5'd0);
    check("jal_stored", RD1, 32'h00003008);
    check("a3zero_we", {31'd0, WE_W}, 32'd0);
    check("r0_rd2", RD2, 32'd0);
    // double-port bypass then storage
    drive(mk_ir(6'h00, 6'h21), 5'd9, 32'd0, 32'hCAFE0001, 32'd0, 5'd9, 5'd9);
    check("byp_rd1", RD1, 32'hCAFE0001);
    check("byp_rd2", RD2, 32'hCAFE0001);
    drive(mk_ir(6'h00, 6'h21), 5'd0, 32'd0, 32'h0, 32'd0, 5'd9, 5'd9);
    check("store_rd1", RD1, 32'hCAFE0001);
    check("store_rd2", RD2, 32'hCAFE0001);
    // misaligned lh
    drive(mk_ir(6'h21, 6'h00), 5'd0, 32'd0, 32'h3003, 32'h80017FFF, 5'd0, 5'd0);
    check("lh_wd", WD_W, 32'hFFFF8001);
    // mid-cycle reset clears storage before the next edge
    drive(mk_ir(6'h00, 6'h21), 5'd5, 32'd0, 32'h1234, 32'd0, 5'd0, 5'd0);
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    check("pre_reset_rd1", RD1, 32'h1234);
    #1 Reset = 1'b1;
    #1 check("async_clear_rd1", RD1, 32'd0);
    // a write edge under reset is discarded, bypass still live
    A3_W = 5'd7; AMO_W = 32'h55AA55AA; A2 = 5'd7;
    #0.5 check("reset_bypass_rd2", RD2, 32'h55AA55AA);
    @(posedge Clock);
    #1 Reset = 1'b0;
    A3_W = 5'd0;
    #1 check("discarded_write", RD2, 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] a3;
      a3 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      drive(($urandom_range(0, 5) == 0) ? $urandom : ops[$urandom_range(0, 7)], a3,
            $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom));
      if ($urandom_range(0, 150) == 0) begin
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
      end
    end
    @(posedge Clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have these ports: Clock  input  1  single clock; all register writes occur on its rising edge.
REQ-002 The block SHALL have these ports: Reset  input  1  asynchronous, active-high; clears the register file immediately, independent of Clock.
REQ-003 The block SHALL have these ports: IR_W  input  32  instruction in W stage.
REQ-004 The block SHALL have these ports: A3_W  input  5  destination register number; 0 means no write.
REQ-005 The block SHALL have these ports: PC4_W  input  32  PC+4 of the W-stage instruction.
REQ-006 The block SHALL have these ports: AMO_W  input  32  ALU result, which is also the memory address for loads.
REQ-007 The block SHALL have these ports: DR_W  input  32  raw memory word read in M stage.
REQ-008 The block SHALL have these ports: A1, A2  input  5 each  read addresses from D stage.
REQ-009 The block SHALL have these ports: RD1, RD2  output  32 each  read data.
REQ-010 The block SHALL have these ports: WD_W  output  32  selected write-back data, for forwarding.
REQ-011 The block SHALL have this port: WE_W  output  1  write enable in effect this cycle.

Function
REQ-012 The block SHALL hold 32 GPRs of 32 bits; $0 SHALL always read as 0 and SHALL never be written.
REQ-013 WE_W SHALL be 1 when A3_W != 0, and 0 otherwise.
REQ-014 WD_W SHALL be selected by opcode IR_W[31:26]:
- lw 0x23: DR_W.
- lb 0x20 / lbu 0x24: byte AMO_W[1:0] of DR_W (byte 0 = bits 7:0), sign- or zero-extended.
- lh 0x21 / lhu 0x25: halfword AMO_W[1] of DR_W, sign- or zero-extended.
- jal 0x03, and R-type (0x00) with funct 0x09 (jalr): PC4_W + 4, wrapping mod 2^32.
- all others: AMO_W.
REQ-015 On the rising edge of Clock with Reset low and WE_W=1, GPR[A3_W] SHALL take WD_W.
REQ-016 Reads SHALL be combinational: RDn = 0 if An = 0; else WD_W if WE_W and An = A3_W (same-cycle write bypass); else GPR[An].
REQ-017 A1 = A2 = A3_W SHALL bypass on both ports simultaneously.
REQ-018 Misaligned lh/lhu (AMO_W[0]=1) SHALL NOT trap; the halfword SHALL be chosen by AMO_W[1] only.
REQ-019 Write latency SHALL be one edge; the written value SHALL be visible through the bypass in the same cycle and from storage afterwards.

Reset
REQ-020 Reset assertion SHALL clear GPR[1..31] to 0 immediately, without waiting for a clock edge.
REQ-021 While Reset is high, no write SHALL occur, and RD1/RD2 SHALL still apply the bypass of REQ-016 from the combinational inputs.
REQ-022 A write edge coinciding with Reset high SHALL be discarded.
REQ-023 Deassertion SHALL take effect on the next edge.

Configuration
REQ-024 With WB_DISPLAY_EN defined, each committed write SHALL print "@<PC4_W-4 hex8>: $<A3_W dec2> <= <WD_W hex8>" once per edge.
REQ-025 Without WB_DISPLAY_EN, no simulation output SHALL be produced.
REQ-026 Functional behaviour SHALL be identical whether or not WB_DISPLAY_EN is defined.

Verification
REQ-027 Reset pulse mid-cycle after loading $5=0x1234 -> RD1 with A1=5 reads 0 before the next edge.
REQ-028 IR_W opcode 0x20, AMO_W=0x3002, DR_W=0x11_80_22_33, A3_W=8 -> WD_W=0xFFFFFF80; after the edge $8=0xFFFFFF80; opcode 0x24 gives 0x00000080.
REQ-029 jal, PC4_W=0x00003004, A3_W=31 -> WD_W=0x00003008; $31=0x00003008.
REQ-030 A3_W=0, AMO_W=0xDEADBEEF -> WE_W=0, $0 still reads 0, and no display line is printed.
REQ-031 A1=A2=A3_W=9, AMO_W=0xCAFE0001, R-type addu -> RD1=RD2=0xCAFE0001 before the edge; after the edge with A3_W=0, storage returns the same value.
REQ-032 lh, AMO_W=0x3003, DR_W=0x8001_7FFF -> WD_W=0xFFFF8001.
